// File: rtl/bist_pattern_engine.sv
// BIST pattern engine: ring / Johnson / LFSR pattern source with an optional
// MISR response compactor (enabled by defining BIST_MISR_EN).
module bist_pattern_engine #(
    parameter int              WIDTH     = 16,
    parameter int              CNT_W     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0]       MODE_NONE    = 2'b00;
    localparam logic [1:0]       MODE_RING    = 2'b01;
    localparam logic [1:0]       MODE_JOHNSON = 2'b10;
    localparam logic [1:0]       MODE_LFSR    = 2'b11;
    localparam logic [WIDTH-1:0] PAT_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] PAT_ZERO     = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

    function automatic logic parity_fn(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    function automatic logic [WIDTH-1:0] next_pattern_fn(input logic [1:0] m,
                                                         input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] n;
        case (m)
            MODE_RING:    n = {p[WIDTH-2:0], p[WIDTH-1]};
            MODE_JOHNSON: n = {p[WIDTH-2:0], ~p[WIDTH-1]};
            MODE_LFSR:    n = {p[WIDTH-2:0], parity_fn(p & LFSR_TAPS)};
            default:      n = p;
        endcase
        return n;
    endfunction

    // An all-zero LFSR state would lock up, so a zero seed becomes 0..01.
    function automatic logic [WIDTH-1:0] initial_pattern_fn(input logic [1:0] m,
                                                            input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        case (m)
            MODE_RING:    n = PAT_ONE;
            MODE_JOHNSON: n = PAT_ZERO;
            MODE_LFSR:    n = (s == PAT_ZERO) ? PAT_ONE : s;
            default:      n = PAT_ZERO;
        endcase
        return n;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] num_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] pattern_r;
    logic             valid_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             advance_s;
    logic             last_s;

    // Next-state decode and pattern-generator enables.
    always_comb begin
        state_s   = state_r;
        load_s    = 1'b0;
        advance_s = 1'b0;
        last_s    = (cnt_r == (num_r - CNT_ONE));
        case (state_r)
            IDLE: begin
                if (start) begin
                    if ((mode != MODE_NONE) && (num_patterns != CNT_ZERO)) begin
                        state_s = RUN;
                        load_s  = 1'b1;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s   = RUN;
                    advance_s = 1'b1;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, run configuration, pattern register and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            mode_r    <= MODE_NONE;
            num_r     <= CNT_ZERO;
            cnt_r     <= CNT_ZERO;
            pattern_r <= PAT_ZERO;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            valid_r <= (state_s == RUN);
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            if (load_s) begin
                mode_r    <= mode;
                num_r     <= num_patterns;
                cnt_r     <= CNT_ZERO;
                pattern_r <= initial_pattern_fn(mode, seed);
            end else if (advance_s) begin
                cnt_r     <= cnt_r + CNT_ONE;
                pattern_r <= next_pattern_fn(mode_r, pattern_r);
            end
        end
    end

`ifdef BIST_MISR_EN
    function automatic logic [WIDTH-1:0] misr_step_fn(input logic [WIDTH-1:0] s,
                                                      input logic [WIDTH-1:0] r);
        return {s[WIDTH-2:0], parity_fn(s & LFSR_TAPS)} ^ r;
    endfunction

    logic [WIDTH-1:0] sig_r;

    // Compacts one response word per valid pattern; frozen outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r <= PAT_ZERO;
        end else if (load_s) begin
            sig_r <= PAT_ZERO;
        end else if (valid_r) begin
            sig_r <= misr_step_fn(sig_r, resp);
        end
    end

    assign signature = sig_r;
`else
    logic unused_resp_s;
    assign unused_resp_s = ^resp;
    assign signature     = PAT_ZERO;
`endif

    assign pattern       = pattern_r;
    assign pattern_valid = valid_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Scoreboard-based self-checking bench for bist_pattern_engine.
module tb_bist_pattern_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        start;
    logic        abort;
    logic [15:0] seed;
    logic [16:0] num_patterns;
    logic [15:0] resp;
    logic [15:0] pattern;
    logic        pattern_valid;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    int          vcnt;
    int          dcnt;
    int          last_v;
    int          done_at;

    bist_pattern_engine #(.WIDTH(16), .CNT_W(17), .LFSR_TAPS(16'hB400)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .abort(abort),
        .seed(seed), .num_patterns(num_patterns), .resp(resp),
        .pattern(pattern), .pattern_valid(pattern_valid), .busy(busy),
        .done(done), .signature(signature)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] p);
        return {p[14:0], ^(p & 16'hB400)};
    endfunction

    // Stimulus only: returns at the falling edge of the first cycle after acceptance.
    task automatic start_run(input logic [1:0] m, input logic [16:0] n, input logic [15:0] s);
        @(negedge clk);
        mode = m; num_patterns = n; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; abort = 1'b0; mode = 2'b01;
        seed = 16'h0000; num_patterns = 17'd4; resp = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({pattern, pattern_valid, busy, done, signature} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got pat=%h v=%b b=%b d=%b sig=%h want all zero",
                     pattern, pattern_valid, busy, done, signature);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ring;
        exp_q = {16'h0001, 16'h0002, 16'h0004, 16'h0008};
        start_run(2'b01, 17'd4, 16'h0000);
        vcnt = 0; dcnt = 0; last_v = -1; done_at = -1;
        for (int c = 0; c < 40 && dcnt == 0; c++) begin
            if (pattern_valid) begin
                vcnt++; last_v = c;
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL ring_busy got %b want 1", busy); end
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL ring_extra got %h want no pattern", pattern);
                end else begin
                    exp_v = exp_q.pop_front();
                    checks++;
                    if (pattern !== exp_v) begin failures++; $display("FAIL ring_pat got %h want %h", pattern, exp_v); end
                end
            end
            if (done) begin dcnt++; done_at = c; end
            @(negedge clk);
        end
        checks++;
        if (vcnt != 4) begin failures++; $display("FAIL ring_count got %0d want 4", vcnt); end
        checks++;
        if (done_at != last_v + 1 || dcnt != 1) begin
            failures++; $display("FAIL ring_done_time got %0d want %0d", done_at, last_v + 1);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL ring_done_pulse got d=%b b=%b want 0 0", done, busy);
        end
    endtask

    // Johnson run while mode/num/seed change and start is raised mid-run.
    task automatic test_johnson_ignore;
        exp_q = {16'h0000, 16'h0001, 16'h0003};
        start_run(2'b10, 17'd3, 16'h1234);
        vcnt = 0; dcnt = 0;
        for (int c = 0; c < 40 && dcnt == 0; c++) begin
            if (pattern_valid) begin
                vcnt++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
                checks++;
                if (pattern !== exp_v) begin failures++; $display("FAIL johnson_pat got %h want %h", pattern, exp_v); end
                if (vcnt == 1) begin mode = 2'b01; num_patterns = 17'd20; seed = 16'hFFFF; start = 1'b1; end
                if (vcnt == 3) start = 1'b0;
            end
            if (done) dcnt++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (vcnt != 3) begin failures++; $display("FAIL johnson_count got %0d want 3", vcnt); end
        repeat (2) @(negedge clk);
        checks++;
        if (pattern !== 16'h0003 || pattern_valid !== 1'b0) begin
            failures++; $display("FAIL johnson_hold got %h v=%b want 0003 v=0", pattern, pattern_valid);
        end
    endtask

    task automatic test_ring_wrap;
        for (int i = 0; i < 17; i++) exp_q.push_back(16'h0001 << (i % 16));
        start_run(2'b01, 17'd17, 16'h0000);
        vcnt = 0; dcnt = 0;
        for (int c = 0; c < 60 && dcnt == 0; c++) begin
            if (pattern_valid) begin
                vcnt++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
                checks++;
                if (pattern !== exp_v) begin failures++; $display("FAIL wrap_pat[%0d] got %h want %h", vcnt, pattern, exp_v); end
            end
            if (done) dcnt++;
            @(negedge clk);
        end
        checks++;
        if (vcnt != 17 || pattern !== 16'h0001) begin
            failures++; $display("FAIL wrap_last got n=%0d pat=%h want 17 0001", vcnt, pattern);
        end
    endtask

    task automatic test_lfsr(input logic [15:0] s, input logic [16:0] n, input int limit);
        exp_v = (s == 16'h0000) ? 16'h0001 : s;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(exp_v);
            exp_v = lfsr_next(exp_v);
        end
        start_run(2'b11, n, s);
        vcnt = 0; dcnt = 0;
        for (int c = 0; c < limit && dcnt == 0; c++) begin
            if (pattern_valid) begin
                vcnt++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
                checks++;
                if (pattern !== exp_v) begin failures++; $display("FAIL lfsr_pat[%0d] got %h want %h", vcnt, pattern, exp_v); end
            end
            if (done) dcnt++;
            @(negedge clk);
        end
        checks++;
        if (vcnt != int'(n) || dcnt != 1) begin
            failures++; $display("FAIL lfsr_count got %0d done=%0d want %0d done=1", vcnt, dcnt, n);
        end
    endtask

    task automatic test_abort;
        exp_q = {16'h0001, 16'h0002, 16'h0004};
        start_run(2'b01, 17'd10, 16'h0000);
        vcnt = 0;
        for (int c = 0; c < 20 && vcnt < 3; c++) begin
            if (pattern_valid) begin
                vcnt++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
                checks++;
                if (pattern !== exp_v) begin failures++; $display("FAIL abort_pat got %h want %h", pattern, exp_v); end
            end
            if (vcnt == 3) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if (pattern_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pattern !== 16'h0004) begin
            failures++; $display("FAIL abort_stop got v=%b b=%b d=%b pat=%h want 0 0 0 0004",
                                 pattern_valid, busy, done, pattern);
        end
        dcnt = 0;
        repeat (4) begin @(negedge clk); if (done || pattern_valid) dcnt++; end
        checks++;
        if (dcnt != 0) begin failures++; $display("FAIL abort_no_done got %0d active cycles want 0", dcnt); end
    endtask

    task automatic test_no_run(input logic [1:0] m, input logic [16:0] n);
        start_run(m, n, 16'h0000);
        checks++;
        if (done !== 1'b1 || pattern_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL norun_done mode=%b n=%0d got d=%b v=%b b=%b want 1 0 0",
                                 m, n, done, pattern_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || pattern_valid !== 1'b0) begin
            failures++; $display("FAIL norun_after got d=%b v=%b want 0 0", done, pattern_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        start_run(2'b11, 17'd10, 16'hACE1);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({pattern, pattern_valid, busy, done, signature} !== 35'd0) begin
            failures++; $display("FAIL rst_mid got pat=%h v=%b b=%b d=%b sig=%h want all zero",
                                 pattern, pattern_valid, busy, done, signature);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        dcnt = 0;
        repeat (4) begin @(negedge clk); if (done || pattern_valid) dcnt++; end
        checks++;
        if (dcnt != 0) begin failures++; $display("FAIL rst_no_done got %0d active cycles want 0", dcnt); end
    endtask

    task automatic test_misr;
        resp = 16'hFFFF;
        start_run(2'b01, 17'd2, 16'h0000);
`ifdef BIST_MISR_EN
        checks++;
        if (signature !== 16'h0000) begin failures++; $display("FAIL misr_clear got %h want 0000", signature); end
        @(negedge clk);
        checks++;
        if (signature !== 16'hFFFF) begin failures++; $display("FAIL misr_step1 got %h want FFFF", signature); end
        @(negedge clk);
        checks++;
        if (signature !== 16'h0001 || done !== 1'b1) begin
            failures++; $display("FAIL misr_step2 got %h d=%b want 0001 d=1", signature, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (signature !== 16'h0001) begin failures++; $display("FAIL misr_hold got %h want 0001", signature); end
`else
        dcnt = 0;
        repeat (5) begin if (signature !== 16'h0000) dcnt++; @(negedge clk); end
        checks++;
        if (dcnt != 0) begin failures++; $display("FAIL sig_const got %0d nonzero cycles want 0", dcnt); end
`endif
        resp = 16'h0000;
    endtask

    // Start held high through DONE: ignored there, accepted once back in IDLE.
    task automatic test_back_to_back;
        start_run(2'b10, 17'd2, 16'h0000);
        for (int c = 0; c < 10 && done !== 1'b1; c++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_first_done got %b want 1", done); end
        mode = 2'b11; num_patterns = 17'd3; seed = 16'hACE1; start = 1'b1;
        exp_q = {16'hACE1, lfsr_next(16'hACE1), lfsr_next(lfsr_next(16'hACE1))};
        @(negedge clk);
        checks++;
        if (pattern_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_done_ignores_start got v=%b b=%b want 0 0", pattern_valid, busy);
        end
        @(negedge clk);
        start = 1'b0;
        vcnt = 0; dcnt = 0;
        for (int c = 0; c < 20 && dcnt == 0; c++) begin
            if (pattern_valid) begin
                vcnt++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
                checks++;
                if (pattern !== exp_v) begin failures++; $display("FAIL b2b_pat got %h want %h", pattern, exp_v); end
            end
            if (done) dcnt++;
            @(negedge clk);
        end
        checks++;
        if (vcnt != 3) begin failures++; $display("FAIL b2b_count got %0d want 3", vcnt); end
    endtask

    initial begin
        test_reset();
        test_ring();
        test_johnson_ignore();
        test_ring_wrap();
        test_lfsr(16'h0000, 17'd3, 20);
        checks++;
        if (pattern !== 16'h0004) begin failures++; $display("FAIL lfsr_seed0_last got %h want 0004", pattern); end
        test_abort();
        test_no_run(2'b01, 17'd0);
        test_no_run(2'b00, 17'd5);
        test_reset_mid_run();
        test_misr();
        test_back_to_back();
        test_lfsr(16'h0001, 17'd65536, 70000);
        checks++;
        if (pattern !== 16'h0001) begin failures++; $display("FAIL lfsr_period_last got %h want 0001", pattern); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_pattern_engine.md
BIST_PATTERN_ENGINE -- requirements
Module: bist_pattern_engine

Interface
REQ-001 The block SHALL have these parameters: WIDTH, 16, pattern/signature width (>=4).
REQ-002 The block SHALL have these parameters: CNT_W, 16, width of pattern-count field.
REQ-003 The block SHALL have these parameters: LFSR_TAPS, 16'hB400, WIDTH-bit feedback tap mask.
REQ-004 The block SHALL have these ports: clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have these ports: rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have these ports: mode  input  2  00 none, 01 ring, 10 Johnson, 11 LFSR.
REQ-007 The block SHALL have these ports: start  input  1  run request, sampled only in IDLE.
REQ-008 The block SHALL have these ports: abort  input  1  terminate run, sampled only in RUN.
REQ-009 The block SHALL have these ports: seed  input  WIDTH  LFSR initial value.
REQ-010 The block SHALL have these ports: num_patterns  input  CNT_W  patterns per run.
REQ-011 The block SHALL have these ports: resp  input  WIDTH  response word from the circuit under test.
REQ-012 The block SHALL have these ports: pattern, pattern_valid, busy, done, signature  outputs  WIDTH/1/1/1/WIDTH.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; busy SHALL be 1 exactly in RUN.
REQ-014 When start=1 in IDLE with mode!=00 and num_patterns!=0, the FSM SHALL latch mode and num_patterns, load the initial pattern and enter RUN on the next edge.
REQ-015 Initial pattern: ring 0..01; Johnson all zeros; LFSR seed, with seed==0 replaced by 0..01.
REQ-016 When start=1 in IDLE with mode==00 or num_patterns==0, the FSM SHALL go directly to DONE and emit no valid patterns.
REQ-017 In RUN, pattern_valid SHALL be 1 every cycle and pattern SHALL advance once per cycle; there are no stalls.
REQ-018 Next-state rules: ring next={p[W-2:0],p[W-1]}; Johnson next={p[W-2:0],~p[W-1]}; LFSR next={p[W-2:0],^(p & LFSR_TAPS)}.
REQ-019 Latency: first valid pattern SHALL appear in the cycle after start is accepted; exactly num_patterns valid cycles per run.
REQ-020 After the last valid cycle the FSM SHALL enter DONE; done SHALL be a one-cycle pulse; DONE SHALL then return to IDLE.
REQ-021 Sequence wrap-around SHALL be free-running: ring repeats after WIDTH patterns, Johnson after 2*WIDTH, LFSR after its period.
REQ-022 mode, seed and num_patterns changes during RUN SHALL be ignored; start in RUN/DONE SHALL be ignored.
REQ-023 abort=1 in RUN SHALL return the FSM to IDLE next edge with no done pulse; pattern_valid SHALL be 0 from that edge.
REQ-024 pattern SHALL hold its last value outside RUN until the next accepted start.
REQ-025 Clock gating SHALL NOT be used; the counters SHALL advance by synchronous enable only.

Reset
REQ-026 rst=1 SHALL force IDLE; pattern, signature=0; pattern_valid, busy, done=0; pattern count=0.
REQ-027 rst SHALL override start and abort in the same cycle, including mid-run; no done pulse SHALL follow a reset.

Configuration
REQ-028 Macro BIST_MISR_EN defined: signature SHALL be cleared on accepted start and, each pattern_valid cycle, update to {s[W-2:0],^(s & LFSR_TAPS)} ^ resp; it SHALL hold outside RUN.
REQ-029 Macro BIST_MISR_EN undefined: signature SHALL be constant 0 and resp SHALL be ignored.

Verification
REQ-030 Ring run: WIDTH=16, mode=01, num_patterns=4 -> patterns 0x0001,0x0002,0x0004,0x0008; done pulse in the cycle after the 4th valid.
REQ-031 Johnson run: mode=10, num_patterns=3 -> 0x0000,0x0001,0x0003. Ring wrap: num_patterns=17 -> 17th pattern 0x0001.
REQ-032 LFSR run: mode=11, seed=0x0000, num_patterns=3 -> 0x0001,0x0002,0x0004. LFSR period: seed=0x0001, num_patterns=65536 -> last pattern 0x0001.
REQ-033 Abort: num_patterns=10, abort during the 3rd valid -> exactly 3 valid cycles, busy 0 next cycle, no done pulse.
REQ-034 Edge cases: start with num_patterns=0 -> done one cycle later, no valid. rst during RUN -> all outputs 0 next edge.
REQ-035 MISR (BIST_MISR_EN): mode=01, num_patterns=2, resp=0xFFFF -> signature 0xFFFF then 0x0001, holding 0x0001 after done.
